cobs_axis_decoder: RTL and testbench

COBS_AXIS_DECODER -- requirements
Module: cobs_axis_decoder

---
 rtl/cobs_axis_decoder.sv | 138 +++++++++++++
 tb/tb_cobs_axis_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cobs_axis_decoder.sv
// COBS stream decoder: 8-bit AXI-Stream in, 16-bit packed AXI-Stream out.
// A 0x00 byte delimits frames. tlast and tuser are attached when the frame ends.
module cobs_axis_decoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [15:0] m_axis_tdata,
   output logic [1:0]  m_axis_tkeep,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   output logic        frame_err
);

   typedef enum logic [1:0] {HUNT, DATA, CODE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic        last_max, last_max_nxt;
   logic [7:0]  low_byte;
   logic        low_valid;
   logic [15:0] stage_word;
   logic        stage_valid;
   logic        accept;
   logic        push;
   logic [7:0]  push_byte;
   logic        frame_end;
   logic        malformed;

   // At most one payload byte or one frame end per accepted byte, so a free
   // output register is enough to accept the next byte.
   assign s_axis_tready = rst_n && (!m_axis_tvalid || m_axis_tready);
   assign accept        = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      last_max_nxt = last_max;
      push         = 1'b0;
      push_byte    = s_axis_tdata;
      frame_end    = 1'b0;
      malformed    = 1'b0;
      if (accept) begin
         case (state)
            HUNT, CODE: begin
               if (s_axis_tdata == 8'h00) begin
                  state_nxt = HUNT;
                  frame_end = (state == CODE);
               end else begin
                  // The implied zero belongs to the previous block, not this code.
                  push         = (state == CODE) && !last_max;
                  push_byte    = 8'h00;
                  last_max_nxt = (s_axis_tdata == 8'hFF);
                  cnt_nxt      = s_axis_tdata - 8'd1;
                  state_nxt    = (s_axis_tdata == 8'h01) ? CODE : DATA;
               end
            end
            DATA: begin
               if (s_axis_tdata == 8'h00) begin
                  state_nxt = HUNT;
                  frame_end = 1'b1;
                  malformed = 1'b1;
                  cnt_nxt   = 8'd0;
               end else begin
                  push    = 1'b1;
                  cnt_nxt = cnt - 8'd1;
                  if (cnt == 8'd1) state_nxt = CODE;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   // A staged word is held back until the next payload byte or the frame end,
   // so the low byte and the staging register are never both occupied.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= HUNT;
         cnt           <= 8'd0;
         last_max      <= 1'b0;
         low_byte      <= 8'd0;
         low_valid     <= 1'b0;
         stage_word    <= 16'd0;
         stage_valid   <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= 16'd0;
         m_axis_tkeep  <= 2'b00;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         last_max  <= last_max_nxt;
         frame_err <= malformed;
         if (m_axis_tready) m_axis_tvalid <= 1'b0;
         if (push) begin
            if (low_valid) begin
               stage_word  <= {push_byte, low_byte};
               stage_valid <= 1'b1;
               low_valid   <= 1'b0;
            end else begin
               low_byte  <= push_byte;
               low_valid <= 1'b1;
               if (stage_valid) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= stage_word;
                  m_axis_tkeep  <= 2'b11;
                  m_axis_tlast  <= 1'b0;
                  m_axis_tuser  <= 1'b0;
                  stage_valid   <= 1'b0;
               end
            end
         end else if (frame_end) begin
            low_valid   <= 1'b0;
            stage_valid <= 1'b0;
            if (stage_valid) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= stage_word;
               m_axis_tkeep  <= 2'b11;
               m_axis_tlast  <= 1'b1;
               m_axis_tuser  <= malformed;
            end else if (low_valid) begin
               m_axis_tvalid <= 1'b1;
               m_axis_tdata  <= {8'h00, low_byte};
               m_axis_tkeep  <= 2'b01;
               m_axis_tlast  <= 1'b1;
               m_axis_tuser  <= malformed;
            end
         end
      end
   end

endmodule

// File: tb/tb_cobs_axis_decoder.sv
// Bench for cobs_axis_decoder: directed and random COBS frames against a
// frame-level reference decoder, with random backpressure on the output.
module tb_cobs_axis_decoder;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [15:0] m_axis_tdata;
   logic [1:0]  m_axis_tkeep;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        frame_err;

   logic [20:0] exp_q[$];
   logic [20:0] mon_obs;
   logic [20:0] hold_val;
   bit          hold_pend = 1'b0;
   bit          bp_mode   = 1'b0;
   bit          gap_mode  = 1'b0;
   int          assert_count = 0;
   int          fail_count   = 0;
   int          err_seen     = 0;
   int          err_exp      = 0;
   int          words_seen   = 0;
   int          stall_count  = 0;

   cobs_axis_decoder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_err     (frame_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Output ready is randomised only while backpressure is enabled.
   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Observed word layout: {tvalid, tuser, tlast, tkeep, tdata}.
   always @(negedge clk) begin
      mon_obs = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      if (rst_n) begin
         if (frame_err) err_seen++;
         if (hold_pend) checkOutput("hold", mon_obs, hold_val);
         hold_pend = m_axis_tvalid && !m_axis_tready;
         hold_val  = mon_obs;
         if (m_axis_tvalid && m_axis_tready) begin
            words_seen++;
            if (exp_q.size() > 0) checkOutput("word", mon_obs, exp_q.pop_front());
            else                  checkOutput("extra_word", mon_obs, 32'hDEADBEEF);
         end
      end else begin
         hold_pend = 1'b0;
      end
   end

   // Reference: decode one delimiter-free frame as whole blocks.
   task automatic decodeFrame(input byte_q_t frame);
      byte_q_t pay;
      bit      bad = 1'b0;
      int      pos = 0;
      int      c;
      while (pos < frame.size()) begin
         c = int'(frame[pos]);
         pos++;
         for (int k = 1; k < c; k++) begin
            if (pos < frame.size()) begin
               pay.push_back(frame[pos]);
               pos++;
            end else begin
               bad = 1'b1;
            end
         end
         if (pos < frame.size() && c < 255) pay.push_back(8'h00);
      end
      if (bad) err_exp++;
      for (int i = 0; i < pay.size(); i += 2) begin
         logic last;
         last = (i + 2 >= pay.size());
         if (i + 1 < pay.size())
            exp_q.push_back({1'b1, last & bad, last, 2'b11, pay[i+1], pay[i]});
         else
            exp_q.push_back({1'b1, bad, 1'b1, 2'b01, 8'h00, pay[i]});
      end
   endtask

   task automatic modelStream(input byte_q_t bytes);
      byte_q_t frame;
      foreach (bytes[i]) begin
         if (bytes[i] == 8'h00) begin
            decodeFrame(frame);
            frame.delete();
         end else begin
            frame.push_back(bytes[i]);
         end
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      bit acc = 1'b0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 1000 && !acc; i++) begin
         @(negedge clk);
         acc = s_axis_tready;
         if (!acc) stall_count++;
         @(posedge clk);
         #1;
      end
      if (!acc) checkOutput("accept_timeout", 32'(acc), 32'd1);
      if (gap_mode && $urandom_range(0, 3) == 0) begin
         s_axis_tvalid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendFrame(input byte_q_t bytes);
      modelStream(bytes);
      foreach (bytes[i]) applyStimulus(bytes[i]);
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 500 && exp_q.size() > 0; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
      checkOutput("frame_err_count", 32'(err_seen), 32'(err_exp));
   endtask

   // One-cycle reset: outputs must be cleared and tready must follow rst_n.
   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  {9'd0, s_axis_tready, frame_err, m_axis_tvalid, m_axis_tuser,
                   m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", 32'(s_axis_tready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic byte_q_t randFrame();
      byte_q_t f;
      int      nb;
      int      c;
      int      cut;
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) f.push_back(8'h00);
      for (int b = 0; b < nb; b++) begin
         c = $urandom_range(1, 9);
         f.push_back(8'(c));
         for (int k = 1; k < c; k++) f.push_back(8'($urandom_range(1, 255)));
      end
      if ($urandom_range(0, 3) == 0 && f.size() > 2) begin
         cut = $urandom_range(1, f.size() - 2);
         repeat (cut) void'(f.pop_back());
      end
      f.push_back(8'h00);
      return f;
   endfunction

   initial begin
      byte_q_t q;
      int      s0;
      int      w0;
      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      repeat (2) @(posedge clk);
      doReset();

      s0 = stall_count;
      q = {8'h03, 8'h34, 8'h12, 8'h00};                 sendFrame(q);
      q = {8'h02, 8'h34, 8'h03, 8'h12, 8'h56, 8'h00};   sendFrame(q);
      q = {8'h02, 8'hAA, 8'h00};                        sendFrame(q);
      q = {8'h01, 8'h00};                               sendFrame(q);
      q = {8'h00};                                      sendFrame(q);
      q = {8'h04, 8'h11, 8'h22, 8'h00};                 sendFrame(q);
      q = {8'h05, 8'h00};                               sendFrame(q);
      q = {8'h01, 8'h01, 8'h02, 8'h7E, 8'h00};          sendFrame(q);
      checkOutput("stalls_no_backpressure", 32'(stall_count - s0), 32'd0);

      bp_mode = 1'b1;
      w0 = words_seen;
      q.delete();
      q.push_back(8'hFF);
      for (int i = 1; i <= 254; i++) q.push_back(8'(i));
      q.push_back(8'h01);
      q.push_back(8'h00);
      sendFrame(q);
      checkOutput("long_block_words", 32'(words_seen - w0), 32'd127);

      bp_mode = 1'b0;
      applyStimulus(8'h03);
      applyStimulus(8'h34);
      s_axis_tvalid = 1'b0;
      doReset();
      q = {8'h03, 8'h56, 8'h78, 8'h00};
      sendFrame(q);

      bp_mode  = 1'b1;
      gap_mode = 1'b1;
      repeat (40) begin
         q = randFrame();
         sendFrame(q);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
